// File: rtl/mux4_scan_pkg.sv
// Shared constants and state encoding for the mux4 round-robin scan controller.
package mux4_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;
endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-channel picker: first enabled channel after 'last',
// with 'last' itself considered only after the other three.
module rr_next_sel
  import mux4_scan_pkg::*;
(
  input  logic [SEL_W-1:0]  last,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt,
  output logic              any
);

  logic [SEL_W-1:0] cand;

  // Walk from farthest to nearest so the nearest enabled candidate wins.
  always_comb begin
    nxt  = last;
    cand = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (mask[cand]) nxt = cand;
    end
  end

  assign any = |mask;

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Time-division scanner for a downstream mux4: steps sel round-robin over the
// enabled channels, waits GUARD settle cycles plus dwell, then captures mux_y.
module mux4_scan_ctrl
  import mux4_scan_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int DWELL_W = 4,
  parameter int GUARD   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [WIDTH-1:0]   mux_y,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   sample,
  output logic [1:0]         sample_ch,
  output logic               sample_vld,
  output logic               busy
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic [SEL_W-1:0]     sample_ch_q, sample_ch_d;
  logic                 sample_vld_q, sample_vld_d;

  logic [SEL_W-1:0]     nxt;
  logic                 any;
  logic                 launch;
  logic [DWELL_W-1:0]   dwell_eff;

  rr_next_sel u_rr (
    .last (last_q),
    .mask (mask),
    .nxt  (nxt),
    .any  (any)
  );

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    gcnt_d       = gcnt_q;
    dcnt_d       = dcnt_q;
    sample_d     = sample_q;
    sample_ch_d  = sample_ch_q;
    sample_vld_d = 1'b0;
    launch       = 1'b0;

    case (state_q)
      ST_IDLE: launch = en && any;
      ST_SETTLE: begin
        gcnt_d = gcnt_q - GW'(1);
        if (gcnt_q == GW'(1)) begin
          state_d = ST_DWELL;
          dcnt_d  = dwell_eff;
        end
      end
      ST_DWELL: begin
        dcnt_d = dcnt_q - DWELL_W'(1);
        if (dcnt_q == DWELL_W'(1)) begin
          sample_d     = mux_y;
          sample_ch_d  = sel_q;
          sample_vld_d = 1'b1;
          launch       = en && any;
          if (!(en && any)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared by the leave-IDLE edge and the back-to-back capture edge.
    if (launch) begin
      sel_d  = nxt;
      last_d = nxt;
      if (GUARD > 0) begin
        state_d = ST_SETTLE;
        gcnt_d  = GW'(GUARD);
      end else begin
        state_d = ST_DWELL;
        dcnt_d  = dwell_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      last_q       <= SEL_W'(NUM_CH - 1);
      gcnt_q       <= '0;
      dcnt_q       <= '0;
      sample_q     <= '0;
      sample_ch_q  <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      gcnt_q       <= gcnt_d;
      dcnt_q       <= dcnt_d;
      sample_q     <= sample_d;
      sample_ch_q  <= sample_ch_d;
      sample_vld_q <= sample_vld_d;
    end
  end

  assign sel        = sel_q;
  assign sample     = sample_q;
  assign sample_ch  = sample_ch_q;
  assign sample_vld = sample_vld_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
